mem_arbiter_cpu_vec: RTL and testbench
======================================

Name: mem_arbiter_cpu_vec

Overview:
Two-requester arbiter that shares one native (valid/ready) memory port between the picorv32 core and the picorv32_pcpi_vec coprocessor. It replaces the two independent memory ports the top level drives today with a single port to unified memory. Requests are granted one at a time and the grant is held until the transaction completes. A watchdog aborts stalled transactions, and an address filter rejects out-of-range requests without touching memory.

Parameters:
ADDR_LIMIT, 1024, byte addresses >= this are rejected locally (never forwarded).
TIMEOUT, 64, max cycles a forwarded transaction may wait for mem_ready before abort; 8-bit counter, legal range 2..255.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
cpu_mem_valid  in  1  core request; held until cpu_mem_ready
cpu_mem_instr  in  1  core instruction fetch
cpu_mem_addr  in  32  core byte address
cpu_mem_wdata  in  32  core write data
cpu_mem_wstrb  in  4  core byte strobes; 0 = read
cpu_mem_ready  out  1  core completion pulse
cpu_mem_rdata  out  32  core read data, valid with cpu_mem_ready
vec_mem_valid  in  1  coprocessor request
vec_mem_addr  in  32  coprocessor byte address
vec_mem_wdata  in  32  coprocessor write data
vec_mem_wstrb  in  4  coprocessor strobes
vec_mem_ready  out  1  coprocessor completion pulse
vec_mem_rdata  out  32  coprocessor read data
mem_valid  out  1  downstream request
mem_instr  out  1  downstream fetch flag; 0 for coprocessor
mem_addr  out  32  downstream address
mem_wdata  out  32  downstream write data
mem_wstrb  out  4  downstream strobes
mem_ready  in  1  downstream completion
mem_rdata  in  32  downstream read data
arb_err  out  1  one-cycle pulse on reject or timeout
arb_err_src  out  1  requester of last error (0 = cpu, 1 = vec); holds until next error

Behaviour:
- States: IDLE, GNT_CPU, GNT_VEC, REJECT, DRAIN.
- Reset: state IDLE, all outputs 0, watchdog 0, priority pointer = cpu.
- IDLE: sample the valids and pick a winner per the arbitration rule.
  - Winner address < ADDR_LIMIT: next state GNT_x.
  - Winner address >= ADDR_LIMIT: next state REJECT.
  - No valid requester: stay in IDLE.
- GNT_x: mem_valid=1. mem_addr/wdata/wstrb/instr come from a registered copy of the winner's request, captured on grant.
  - x_mem_ready = mem_ready, combinational pass-through.
  - x_mem_rdata = mem_rdata while granted; 0 otherwise.
  - mem_ready=1: transaction done, next state IDLE.
- Grant latency: request seen in IDLE at edge N gives mem_valid high from edge N+1. Minimum occupancy is 2 cycles per transaction.
- One IDLE cycle always separates consecutive grants. This guarantees a requester's valid has dropped before it is sampled again.
- The loser's valid stays pending; it is never acknowledged while the other requester holds the grant.
- mem_ready arriving while in IDLE or REJECT is ignored.
- Watchdog: counts cycles in GNT_x. When it reaches TIMEOUT with no mem_ready:
  - mem_valid is dropped;
  - x_mem_ready is pulsed with rdata=0;
  - arb_err is pulsed and arb_err_src is set;
  - next state DRAIN.
- DRAIN: waits for mem_ready or 4 cycles, whichever comes first, so a late completion is swallowed. Next state IDLE.
- REJECT: lasts 1 cycle. mem_valid stays 0; x_mem_ready pulses with rdata 0xFFFFFFFF; arb_err pulses. Next state IDLE.
- Fixed arbitration (macro off): the coprocessor wins a simultaneous request.
- Reset asserted mid-transaction:
  - all state returns to IDLE next edge and mem_valid drops;
  - no ready pulse is issued;
  - a late mem_ready after reset is ignored.

Optional Feature:
MEM_ARB_RR_EN.
- Defined: round-robin arbitration. The priority pointer flips to the other requester after each completed, rejected or timed-out grant. A simultaneous request goes to the requester the pointer favours. Under continuous requests from both sides, grants strictly alternate.
- Undefined: fixed priority, vec > cpu, and no pointer register is built. The coprocessor can starve the core during long strided vector loads; this is an accepted risk.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum;
  - requester ID constants (REQ_CPU=0, REQ_VEC=1);
  - REJECT_RDATA constant = 0xFFFFFFFF;
  - DRAIN_CYCLES constant = 4.
- One sub-module, mem_arb_watchdog: loadable 8-bit counter with start, clear and expire signals. Used by both GNT_x and DRAIN.

Test Plan:
- CPU-only read at 0x10, memory ready after 1 cycle -> mem_valid 1 cycle after request; cpu_mem_ready pulses once with the memory word; vec_mem_ready stays 0.
- CPU and vec request in the same cycle at 0x190 and 0x1A0:
  - macro off -> vec served first, cpu after one IDLE gap;
  - macro on, pointer=cpu -> cpu first, then vec.
- Vec write addr 0x1B4, wdata 0x00000000, wstrb 0xF -> memory word cleared; cpu read of 0x1B4 that follows returns 0.
- Vec request at addr 1024 -> mem_valid never rises; vec_mem_ready pulses with 0xFFFFFFFF; arb_err=1, arb_err_src=1.
- mem_ready held low, TIMEOUT=8 -> at cycle 8 mem_valid drops, cpu_mem_ready pulses with 0, arb_err pulses; a late mem_ready at cycle 10 is swallowed by DRAIN.
- reset asserted while in GNT_VEC -> next edge mem_valid=0, state IDLE, no vec_mem_ready pulse.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the cpu/vector memory arbiter.
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GNT_CPU,
    GNT_VEC,
    REJECT,
    DRAIN
  } arb_state_t;

  localparam logic        REQ_CPU      = 1'b0;
  localparam logic        REQ_VEC      = 1'b1;
  localparam logic [31:0] REJECT_RDATA = 32'hFFFF_FFFF;
  localparam logic [7:0]  DRAIN_CYCLES = 8'd4;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Loadable 8-bit down-counter; expire flags the last cycle of a loaded window.
module mem_arb_watchdog (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] load_val,
  output logic       expire
);

  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (start) begin
      cnt <= load_val;
    end else if (cnt != 8'd0) begin
      cnt <= cnt - 8'd1;
    end
  end

  // A window loaded with N expires in its N-th cycle.
  assign expire = (cnt == 8'd1);

endmodule

// File: rtl/mem_arbiter_cpu_vec.sv
// Shares one valid/ready memory port between picorv32 and its vector coprocessor.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is fixed vec > cpu.
module mem_arbiter_cpu_vec
  import mem_arb_pkg::*;
#(
  parameter int ADDR_LIMIT = 1024,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_mem_valid,
  input  logic        cpu_mem_instr,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_wdata,
  input  logic [3:0]  cpu_mem_wstrb,
  output logic        cpu_mem_ready,
  output logic [31:0] cpu_mem_rdata,
  input  logic        vec_mem_valid,
  input  logic [31:0] vec_mem_addr,
  input  logic [31:0] vec_mem_wdata,
  input  logic [3:0]  vec_mem_wstrb,
  output logic        vec_mem_ready,
  output logic [31:0] vec_mem_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        arb_err,
  output logic        arb_err_src
);

  localparam logic [7:0]  TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic [31:0] LIMIT       = 32'(ADDR_LIMIT);

  arb_state_t  state;
  logic        req;
  logic        abort;
  logic        win;
  logic        any_valid;
  logic [31:0] win_addr;
  logic        wd_start;
  logic        wd_clear;
  logic        wd_expire;
  logic [7:0]  wd_load;
  logic        cpu_gnt;
  logic        vec_gnt;

  assign any_valid = cpu_mem_valid | vec_mem_valid;

`ifdef MEM_ARB_RR_EN
  logic ptr;

  always_comb begin
    win = vec_mem_valid ? REQ_VEC : REQ_CPU;
    if (cpu_mem_valid && vec_mem_valid) win = ptr;
  end

  // Hand priority to the other side whenever a grant finishes in any way.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= REQ_CPU;
    end else if (((state == GNT_CPU || state == GNT_VEC) && (mem_ready || wd_expire)) ||
                 state == REJECT) begin
      ptr <= ~req;
    end
  end
`else
  assign win = vec_mem_valid ? REQ_VEC : REQ_CPU;
`endif

  assign win_addr = (win == REQ_VEC) ? vec_mem_addr : cpu_mem_addr;

  always_comb begin
    wd_start = 1'b0;
    wd_clear = 1'b0;
    wd_load  = TIMEOUT_CNT;
    case (state)
      IDLE: wd_start = any_valid && (win_addr < LIMIT);
      GNT_CPU, GNT_VEC: begin
        if (mem_ready) begin
          wd_clear = 1'b1;
        end else if (wd_expire) begin
          wd_start = 1'b1;
          wd_load  = DRAIN_CYCLES;
        end
      end
      DRAIN: wd_clear = mem_ready || wd_expire;
      default: ;
    endcase
  end

  mem_arb_watchdog u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .start    (wd_start),
    .clear    (wd_clear),
    .load_val (wd_load),
    .expire   (wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      req         <= REQ_CPU;
      abort       <= 1'b0;
      arb_err     <= 1'b0;
      arb_err_src <= 1'b0;
      mem_valid   <= 1'b0;
      mem_instr   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
    end else begin
      abort   <= 1'b0;
      arb_err <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            req <= win;
            if (win_addr < LIMIT) begin
              state     <= (win == REQ_VEC) ? GNT_VEC : GNT_CPU;
              mem_valid <= 1'b1;
              mem_instr <= (win == REQ_CPU) & cpu_mem_instr;
              mem_addr  <= win_addr;
              mem_wdata <= (win == REQ_VEC) ? vec_mem_wdata : cpu_mem_wdata;
              mem_wstrb <= (win == REQ_VEC) ? vec_mem_wstrb : cpu_mem_wstrb;
            end else begin
              state       <= REJECT;
              arb_err     <= 1'b1;
              arb_err_src <= win;
            end
          end
        end
        GNT_CPU, GNT_VEC: begin
          if (mem_ready) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
          end else if (wd_expire) begin
            state       <= DRAIN;
            mem_valid   <= 1'b0;
            abort       <= 1'b1;
            arb_err     <= 1'b1;
            arb_err_src <= req;
          end
        end
        REJECT: state <= IDLE;
        DRAIN: begin
          if (mem_ready || wd_expire) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cpu_gnt = (state == GNT_CPU);
  assign vec_gnt = (state == GNT_VEC);

  // Abort acknowledges arrive in the first DRAIN cycle; reset suppresses all acks.
  assign cpu_mem_ready = !reset && ((cpu_gnt && mem_ready) ||
                                    ((state == REJECT || abort) && req == REQ_CPU));
  assign vec_mem_ready = !reset && ((vec_gnt && mem_ready) ||
                                    ((state == REJECT || abort) && req == REQ_VEC));

  always_comb begin
    cpu_mem_rdata = '0;
    vec_mem_rdata = '0;
    if (cpu_gnt) cpu_mem_rdata = mem_rdata;
    else if (state == REJECT && req == REQ_CPU) cpu_mem_rdata = REJECT_RDATA;
    if (vec_gnt) vec_mem_rdata = mem_rdata;
    else if (state == REJECT && req == REQ_VEC) vec_mem_rdata = REJECT_RDATA;
  end

endmodule

// File: tb/tb_mem_arbiter_cpu_vec.sv
// Scoreboard bench for mem_arbiter_cpu_vec with a behavioural memory and reference model.
module tb_mem_arbiter_cpu_vec;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_mem_valid, cpu_mem_instr;
  logic [31:0] cpu_mem_addr, cpu_mem_wdata;
  logic [3:0]  cpu_mem_wstrb;
  logic        cpu_mem_ready;
  logic [31:0] cpu_mem_rdata;
  logic        vec_mem_valid;
  logic [31:0] vec_mem_addr, vec_mem_wdata;
  logic [3:0]  vec_mem_wstrb;
  logic        vec_mem_ready;
  logic [31:0] vec_mem_rdata;
  logic        mem_valid, mem_instr;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        arb_err, arb_err_src;

  always #5 clk = ~clk;

  mem_arbiter_cpu_vec #(.ADDR_LIMIT(1024), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .cpu_mem_valid(cpu_mem_valid), .cpu_mem_instr(cpu_mem_instr),
    .cpu_mem_addr(cpu_mem_addr), .cpu_mem_wdata(cpu_mem_wdata),
    .cpu_mem_wstrb(cpu_mem_wstrb), .cpu_mem_ready(cpu_mem_ready),
    .cpu_mem_rdata(cpu_mem_rdata),
    .vec_mem_valid(vec_mem_valid), .vec_mem_addr(vec_mem_addr),
    .vec_mem_wdata(vec_mem_wdata), .vec_mem_wstrb(vec_mem_wstrb),
    .vec_mem_ready(vec_mem_ready), .vec_mem_rdata(vec_mem_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .arb_err(arb_err), .arb_err_src(arb_err_src)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rd;
  } exp_t;

  exp_t        cpu_exp[$];
  exp_t        vec_exp[$];
  int          order[$];
  int          compared   = 0;
  int          mismatched = 0;
  int          mv_cycles  = 0;
  logic [31:0] mem[256];
  logic [31:0] ref_mem[256];
  logic        stall    = 1'b0;
  logic        late_req = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA500_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // Reference: out-of-range -> reject word with error, write -> 0, read -> current word.
  function automatic exp_t predict(input logic [31:0] a, input logic [31:0] d,
                                   input logic [3:0] s);
    exp_t e;
    if (a >= 32'd1024) begin
      e.err = 1'b1;
      e.rd  = 32'hFFFF_FFFF;
    end else if (s == 4'h0) begin
      e.err = 1'b0;
      e.rd  = ref_mem[a[9:2]];
    end else begin
      e.err = 1'b0;
      e.rd  = 32'h0;
      ref_mem[a[9:2]] = merge(ref_mem[a[9:2]], d, s);
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic cpu_do(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input logic ins, input exp_t e);
    int n = 0;
    cpu_exp.push_back(e);
    cpu_mem_valid = 1'b1; cpu_mem_addr = a; cpu_mem_wdata = d;
    cpu_mem_wstrb = s;    cpu_mem_instr = ins;
    do begin @(negedge clk); n++; end while (!cpu_mem_ready && n < 300);
    if (!cpu_mem_ready) begin
      compared++; mismatched++;
      $display("FAIL cpu_wait: no ready after %0d cycles, required a ready pulse", n);
      void'(cpu_exp.pop_back());
    end
    @(posedge clk); #1;
    cpu_mem_valid = 1'b0;
  endtask

  task automatic vec_do(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input exp_t e);
    int n = 0;
    vec_exp.push_back(e);
    vec_mem_valid = 1'b1; vec_mem_addr = a; vec_mem_wdata = d; vec_mem_wstrb = s;
    do begin @(negedge clk); n++; end while (!vec_mem_ready && n < 300);
    if (!vec_mem_ready) begin
      compared++; mismatched++;
      $display("FAIL vec_wait: no ready after %0d cycles, required a ready pulse", n);
      void'(vec_exp.pop_back());
    end
    @(posedge clk); #1;
    vec_mem_valid = 1'b0;
  endtask

  // Memory: answers after 0..2 wait cycles unless stalled; can inject one stray ready.
  initial begin
    int w = -1;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 1'b0;
      mem_rdata = '0;
      if (late_req) begin
        mem_ready = 1'b1;
        late_req  = 1'b0;
        w = -1;
      end else if (mem_valid && !stall && !reset) begin
        if (w < 0) w = int'($urandom_range(0, 2));
        if (w == 0) begin
          mem_ready = 1'b1;
          if (mem_wstrb == 4'h0) mem_rdata = mem[mem_addr[9:2]];
          else mem[mem_addr[9:2]] = merge(mem[mem_addr[9:2]], mem_wdata, mem_wstrb);
          w = -1;
        end else begin
          w--;
        end
      end else begin
        w = -1;
      end
    end
  end

  // Monitor: every ready pulse pops the requester's expected response.
  initial begin
    exp_t e;
    logic prev_rdy;
    prev_rdy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (mem_valid) mv_cycles++;
        if (prev_rdy) chk("idle_gap_mem_valid", {31'b0, mem_valid}, 32'h0);
        if (cpu_mem_ready) begin
          order.push_back(0);
          if (cpu_exp.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL cpu_unexpected_ready: got ready with rdata %h, required no ready",
                     cpu_mem_rdata);
          end else begin
            e = cpu_exp.pop_front();
            chk("cpu_rdata", cpu_mem_rdata, e.rd);
            chk("cpu_err", {31'b0, arb_err}, {31'b0, e.err});
            if (e.err) chk("cpu_err_src", {31'b0, arb_err_src}, 32'h0);
          end
        end
        if (vec_mem_ready) begin
          order.push_back(1);
          if (vec_exp.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL vec_unexpected_ready: got ready with rdata %h, required no ready",
                     vec_mem_rdata);
          end else begin
            e = vec_exp.pop_front();
            chk("vec_rdata", vec_mem_rdata, e.rd);
            chk("vec_err", {31'b0, arb_err}, {31'b0, e.err});
            if (e.err) chk("vec_err_src", {31'b0, arb_err_src}, 32'h1);
          end
        end
        if (arb_err && !cpu_mem_ready && !vec_mem_ready)
          chk("stray_err", {31'b0, arb_err}, 32'h0);
        prev_rdy = cpu_mem_ready | vec_mem_ready;
      end else begin
        prev_rdy = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation still running, required completion");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    exp_t e1, e2;
    int   mv0;
    int   n;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = init_word(i);
      ref_mem[i] = init_word(i);
    end
    reset = 1'b1;
    cpu_mem_valid = 0; cpu_mem_instr = 0; cpu_mem_addr = '0; cpu_mem_wdata = '0;
    cpu_mem_wstrb = '0;
    vec_mem_valid = 0; vec_mem_addr = '0; vec_mem_wdata = '0; vec_mem_wstrb = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("rst_arb_err", {31'b0, arb_err}, 32'h0);
    chk("rst_err_src", {31'b0, arb_err_src}, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_cpu_ready", {31'b0, cpu_mem_ready}, 32'h0);
    chk("rst_vec_ready", {31'b0, vec_mem_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Simultaneous requests straight after reset (pointer favours cpu).
    e1 = predict(32'h190, 32'h0, 4'h0);
    e2 = predict(32'h1A0, 32'h0, 4'h0);
    order.delete();
    fork
      cpu_do(32'h190, 32'h0, 4'h0, 1'b0, e1);
      vec_do(32'h1A0, 32'h0, 4'h0, e2);
    join
    chk("simul_count", order.size(), 32'd2);
    if (order.size() == 2) begin
`ifdef MEM_ARB_RR_EN
      chk("simul_first", order[0], 32'd0);
      chk("simul_second", order[1], 32'd1);
`else
      chk("simul_first", order[0], 32'd1);
      chk("simul_second", order[1], 32'd0);
`endif
    end

    // CPU-only fetch with grant latency check.
    e1 = predict(32'h10, 32'h0, 4'h0);
    fork
      cpu_do(32'h10, 32'h0, 4'h0, 1'b1, e1);
      begin
        @(negedge clk);
        chk("lat_req_cycle", {31'b0, mem_valid}, 32'h0);
        @(negedge clk);
        chk("lat_next_cycle", {31'b0, mem_valid}, 32'h1);
        chk("lat_instr", {31'b0, mem_instr}, 32'h1);
        chk("lat_addr", mem_addr, 32'h10);
      end
    join

    // Vector clears a word, then the core reads it back.
    vec_do(32'h1B4, 32'h0, 4'hF, predict(32'h1B4, 32'h0, 4'hF));
    cpu_do(32'h1B4, 32'h0, 4'h0, 1'b0, predict(32'h1B4, 32'h0, 4'h0));
    chk("clear_ref", ref_mem[8'h6D], 32'h0);

    // Out-of-range vector request never reaches memory.
    mv0 = mv_cycles;
    vec_do(32'h400, 32'h0, 4'h0, predict(32'h400, 32'h0, 4'h0));
    chk("reject_no_mem_valid", mv_cycles, mv0);
    chk("reject_err_src_hold", {31'b0, arb_err_src}, 32'h1);

    // Random traffic; write regions are disjoint per requester.
    fork
      begin
        logic [31:0] ca, cd;
        logic [3:0]  cs;
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(0, 3) == 0) ca = 32'h400 + 32'($urandom_range(0, 255)) * 32'd4;
          else ca = 32'($urandom_range(0, 63)) * 32'd4;
          cd = $urandom;
          cs = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          cpu_do(ca, cd, cs, 1'($urandom_range(0, 1)), predict(ca, cd, cs));
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
        end
      end
      begin
        logic [31:0] va, vd;
        logic [3:0]  vs;
        for (int j = 0; j < 40; j++) begin
          if ($urandom_range(0, 3) == 0) va = 32'h800 + 32'($urandom_range(0, 255)) * 32'd4;
          else va = 32'h100 + 32'($urandom_range(0, 63)) * 32'd4;
          vd = $urandom;
          vs = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'h0;
          vec_do(va, vd, vs, predict(va, vd, vs));
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
      end
    join

    // Stalled memory: watchdog abort, then a late ready swallowed by DRAIN.
    stall = 1'b1;
    fork
      cpu_do(32'h20, 32'h0, 4'h0, 1'b0, {1'b1, 32'h0});
      begin
        int hi = 0;
        n = 0;
        while (!mem_valid && n < 20) begin @(negedge clk); n++; end
        while (mem_valid && hi < 50) begin hi++; @(negedge clk); end
        chk("timeout_valid_cycles", hi, TO);
        @(negedge clk);
        late_req = 1'b1;
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk("drain_idle_mem_valid", {31'b0, mem_valid}, 32'h0);

    // Reset while the vector holds the grant.
    vec_mem_valid = 1'b1; vec_mem_addr = 32'h120; vec_mem_wstrb = 4'h0;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_valid && n < 20);
    chk("rstmid_granted", {31'b0, mem_valid}, 32'h1);
    @(posedge clk); #1;
    reset = 1'b1;
    vec_mem_valid = 1'b0;
    @(negedge clk);
    chk("rstmid_no_ready_in_reset", {31'b0, vec_mem_ready}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rstmid_mem_valid", {31'b0, mem_valid}, 32'h0);
    chk("rstmid_vec_ready", {31'b0, vec_mem_ready}, 32'h0);
    late_req = 1'b1;
    repeat (3) @(negedge clk);
    chk("rstmid_late_mem_valid", {31'b0, mem_valid}, 32'h0);
    stall = 1'b0;

    repeat (4) @(posedge clk);
    chk("cpu_exp_drained", cpu_exp.size(), 32'd0);
    chk("vec_exp_drained", vec_exp.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
